first_system_mem_master: RTL and testbench

FIRST_SYSTEM_MEM_MASTER -- requirements
Module: first_system_mem_master

---
 rtl/first_system_mem_pkg.sv | 15 +
 rtl/first_system_rd_pipe.sv | 46 ++++
 rtl/first_system_mem_master.sv | 195 +++++++++++++++++++
 tb/tb_first_system_mem_master.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/first_system_mem_pkg.sv
// Shared types and defaults for the memory fill/check master.
// Holds the FSM state encoding and the default read latency.
package first_system_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_CHECK,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int READ_LATENCY_DEF = 1;

endpackage

// File: rtl/first_system_rd_pipe.sv
// Fixed-depth compare pipeline: carries a read's valid bit,
// its expected data and its address until the read data is due.
module first_system_rd_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32,
   parameter int AW    = 13
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AW-1:0]    in_addr,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_addr
);

   logic [DEPTH-1:0] vld_q;
   logic [WIDTH-1:0] dat_q [DEPTH];
   logic [AW-1:0]    adr_q [DEPTH];

   // shift register; reset clears every stage so stale compares vanish
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat_q[k] <= '0;
            adr_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= in_valid;
         dat_q[0] <= in_data;
         adr_q[0] <= in_addr;
         for (int k = 1; k < DEPTH; k++) begin
            vld_q[k] <= vld_q[k-1];
            dat_q[k] <= dat_q[k-1];
            adr_q[k] <= adr_q[k-1];
         end
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign out_data  = dat_q[DEPTH-1];
   assign out_addr  = adr_q[DEPTH-1];

endmodule

// File: rtl/first_system_mem_master.sv
// Memory test master: writes seed+i to a word range, reads it back
// and counts mismatches. All memory port outputs are registered.
module first_system_mem_master
   import first_system_mem_pkg::*;
#(
   parameter int ADDR_W       = 13,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = READ_LATENCY_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     word_count,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [15:0]         err_count,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [ADDR_W-1:0]   m_address,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic                m_chipselect,
   output logic                m_write,
   output logic [DATA_W-1:0]   m_writedata,
   output logic                m_clken,
   input  logic [DATA_W-1:0]   m_readdata
);

   localparam int BE_W = DATA_W / 8;
   localparam int CW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [ADDR_W:0] MAX_N = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_N = {{ADDR_W{1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W:0]     idx_q, idx_d, nidx;
   logic [ADDR_W:0]     n_q, n_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [CW-1:0]       drain_q, drain_d;
   logic [15:0]         err_cnt_d;
   logic [ADDR_W-1:0]   err_addr_d;
   logic                pass_d;
   logic [ADDR_W-1:0]   addr_d;
   logic [DATA_W-1:0]   wdata_d;
   logic [BE_W-1:0]     be_d;
   logic                cs_d, we_d;
   logic                p_valid;
   logic [DATA_W-1:0]   p_data;
   logic [ADDR_W-1:0]   p_addr;
   logic [DATA_W-1:0]   exp_now;

   assign nidx    = idx_q + ONE_N;
   assign exp_now = seed_q + DATA_W'(idx_q);
   assign busy    = (state_q != ST_IDLE);
   assign done    = (state_q == ST_DONE);

   first_system_rd_pipe #(
      .DEPTH (READ_LATENCY),
      .WIDTH (DATA_W),
      .AW    (ADDR_W)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (state_q == ST_CHECK),
      .in_data   (exp_now),
      .in_addr   (m_address),
      .out_valid (p_valid),
      .out_data  (p_data),
      .out_addr  (p_addr)
   );

   // next state, next bus outputs and result bookkeeping
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      n_d        = n_q;
      base_d     = base_q;
      seed_d     = seed_q;
      drain_d    = drain_q;
      err_cnt_d  = err_count;
      err_addr_d = err_addr;
      pass_d     = pass;
      addr_d     = m_address;
      wdata_d    = m_writedata;
      be_d       = '0;
      cs_d       = 1'b0;
      we_d       = 1'b0;

      if (p_valid && (m_readdata != p_data)) begin
         if (err_count != 16'hFFFF)
            err_cnt_d = err_count + 16'd1;
         if (err_count == 16'd0)
            err_addr_d = p_addr;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_d     = base_addr;
               seed_d     = seed;
               n_d        = (word_count > MAX_N) ? MAX_N : word_count;
               idx_d      = '0;
               err_cnt_d  = '0;
               err_addr_d = '0;
               pass_d     = 1'b0;
               if (word_count == '0) begin
                  state_d = ST_DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = ST_FILL;
                  addr_d  = base_addr;
                  wdata_d = seed;
                  be_d    = '1;
                  cs_d    = 1'b1;
                  we_d    = 1'b1;
               end
            end
         end
         ST_FILL: begin
            be_d = '1;
            cs_d = 1'b1;
            if (nidx == n_q) begin
               state_d = ST_CHECK;
               idx_d   = '0;
               addr_d  = base_q;
            end else begin
               idx_d   = nidx;
               addr_d  = base_q + nidx[ADDR_W-1:0];
               wdata_d = seed_q + DATA_W'(nidx);
               we_d    = 1'b1;
            end
         end
         ST_CHECK: begin
            if (nidx == n_q) begin
               state_d = ST_DRAIN;
               drain_d = '0;
            end else begin
               idx_d  = nidx;
               addr_d = base_q + nidx[ADDR_W-1:0];
               be_d   = '1;
               cs_d   = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == CW'(READ_LATENCY - 1)) begin
               state_d = ST_DONE;
               pass_d  = (err_cnt_d == 16'd0);
            end else begin
               drain_d = drain_q + CW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // state, results and registered memory port
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         n_q          <= '0;
         base_q       <= '0;
         seed_q       <= '0;
         drain_q      <= '0;
         err_count    <= '0;
         err_addr     <= '0;
         pass         <= 1'b0;
         m_address    <= '0;
         m_writedata  <= '0;
         m_byteenable <= '0;
         m_chipselect <= 1'b0;
         m_write      <= 1'b0;
         m_clken      <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         n_q          <= n_d;
         base_q       <= base_d;
         seed_q       <= seed_d;
         drain_q      <= drain_d;
         err_count    <= err_cnt_d;
         err_addr     <= err_addr_d;
         pass         <= pass_d;
         m_address    <= addr_d;
         m_writedata  <= wdata_d;
         m_byteenable <= be_d;
         m_chipselect <= cs_d;
         m_write      <= we_d;
         m_clken      <= 1'b1;
      end
   end

endmodule

// File: tb/tb_first_system_mem_master.sv
// Bench for first_system_mem_master: directed vector table,
// corner sequences and random runs against a reference model.
module tb_first_system_mem_master;

   localparam int LIMIT = 20000;
   localparam int RL    = 1;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [12:0] base_addr;
   logic [13:0] word_count;
   logic [31:0] seed;
   logic        busy, done, pass;
   logic [15:0] err_count;
   logic [12:0] err_addr;
   logic [12:0] m_address;
   logic [3:0]  m_byteenable;
   logic        m_chipselect, m_write, m_clken;
   logic [31:0] m_writedata, m_readdata;

   first_system_mem_master dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .seed         (seed),
      .busy         (busy),
      .done         (done),
      .pass         (pass),
      .err_count    (err_count),
      .err_addr     (err_addr),
      .m_address    (m_address),
      .m_byteenable (m_byteenable),
      .m_chipselect (m_chipselect),
      .m_write      (m_write),
      .m_writedata  (m_writedata),
      .m_clken      (m_clken),
      .m_readdata   (m_readdata)
   );

   always #5 clk = ~clk;

   // 5120x32 single-port memory, address registered, output unregistered
   logic [31:0] mem [5120];
   logic [12:0] rd_a = '0;
   logic        corrupt_en = 1'b0;
   logic [12:0] corrupt_addr = '0;

   always @(posedge clk) begin
      if (m_clken && m_chipselect) begin
         if (m_write)
            for (int b = 0; b < 4; b++)
               if (m_byteenable[b])
                  mem[int'(m_address) % 5120][b*8 +: 8] <= m_writedata[b*8 +: 8];
         rd_a <= m_address;
      end
   end

   assign m_readdata = (corrupt_en && rd_a == corrupt_addr) ?
                       32'h0 : mem[int'(rd_a) % 5120];

   // bus monitor
   typedef struct packed {
      logic        wr;
      logic [12:0] a;
      logic [31:0] d;
      logic [3:0]  be;
   } bus_t;

   bus_t trace[$];
   bit   clken_bad = 1'b0;

   always @(negedge clk) begin
      if (!reset && m_chipselect)
         trace.push_back('{m_write, m_address, m_writedata, m_byteenable});
      if (!reset && m_clken !== 1'b1)
         clken_bad = 1'b1;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // reference model: results and run length from the run parameters
   function automatic void ref_model(
      input logic [12:0] b, input int cnt, input logic [31:0] s,
      input bit cor, input logic [12:0] ca,
      output bit ep, output int ee, output logic [12:0] ea,
      output int ec);
      int nn;
      logic [12:0] a;
      logic [31:0] d;
      nn = (cnt > 8192) ? 8192 : cnt;
      ee = 0;
      ea = '0;
      for (int i = 0; i < nn; i++) begin
         a = b + 13'(i);
         d = s + 32'(i);
         if (cor && a == ca && d != 32'h0) begin
            if (ee == 0) ea = a;
            if (ee < 65535) ee++;
         end
      end
      ep = (ee == 0);
      ec = (nn == 0) ? 1 : 2 * nn + RL + 1;
   endfunction

   task automatic check_trace(input string nm, input logic [12:0] b,
                              input int n, input logic [31:0] s);
      int bad;
      int k;
      bus_t e;
      bad = -1;
      chk({nm, " trace_len"}, trace.size(), 2 * n);
      if (trace.size() == 2 * n) begin
         for (int j = 0; j < 2 * n; j++) begin
            k = j % n;
            e = trace[j];
            if (j < n) begin
               if (!(e.wr && e.a == b + 13'(k) && e.d == s + 32'(k) &&
                     e.be == 4'hF) && bad < 0)
                  bad = j;
            end else begin
               if (!(!e.wr && e.a == b + 13'(k)) && bad < 0)
                  bad = j;
            end
         end
      end
      chk({nm, " trace_first_bad"}, bad, -1);
   endtask

   logic        r_pass;
   logic [15:0] r_err;
   logic [12:0] r_eaddr;
   logic        r_busy1;

   task automatic run_one(input logic [12:0] b, input logic [13:0] n,
                          input logic [31:0] s, input bit cor,
                          input logic [12:0] ca, input int restart_at,
                          output int cyc, output bit pulse_ok);
      corrupt_en   = cor;
      corrupt_addr = ca;
      @(negedge clk);
      trace.delete();
      base_addr  = b;
      word_count = n;
      seed       = s;
      start      = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      cyc     = 1;
      r_busy1 = busy;
      while (!done && cyc < LIMIT) begin
         start = (cyc == restart_at);
         if (start) begin
            base_addr  = 13'h50;
            word_count = 14'd2;
            seed       = 32'h0;
         end
         @(negedge clk);
         cyc++;
      end
      start   = 1'b0;
      r_pass  = pass;
      r_err   = err_count;
      r_eaddr = err_addr;
      if (!done) cyc = -1;
      @(negedge clk);
      pulse_ok = !done && !busy;
   endtask

   typedef struct {
      logic [12:0] base;
      logic [13:0] cnt;
      logic [31:0] seed;
      bit          cor;
      logic [12:0] caddr;
      bit          e_pass;
      int          e_err;
      logic [12:0] e_eaddr;
      int          e_cyc;
   } vec_t;

   vec_t vt[7];

   initial begin
      int  cyc;
      bit  pok;
      bit  ep;
      int  ee, ec, nn;
      logic [12:0] ea, rb, rca;
      logic [31:0] rs;
      bit  rc;
      string nm;

      vt[0] = '{13'h0000, 14'd16, 32'hA5A50000, 1'b0, 13'h0,
                1'b1, 0, 13'h0, 34};
      vt[1] = '{13'h0000, 14'd16, 32'hA5A50000, 1'b1, 13'h5,
                1'b0, 1, 13'h5, 34};
      vt[2] = '{13'h0123, 14'd0, 32'h12345678, 1'b0, 13'h0,
                1'b1, 0, 13'h0, 1};
      vt[3] = '{13'h1FFE, 14'd4, 32'h12345678, 1'b0, 13'h0,
                1'b1, 0, 13'h0, 10};
      vt[4] = '{13'h0100, 14'd1, 32'hFFFFFFFF, 1'b1, 13'h100,
                1'b0, 1, 13'h100, 4};
      vt[5] = '{13'h1FFF, 14'd3, 32'hFFFFFFFE, 1'b1, 13'h0,
                1'b0, 1, 13'h0, 8};
      vt[6] = '{13'h0010, 14'd4, 32'hFFFFFFFE, 1'b1, 13'h12,
                1'b1, 0, 13'h0, 10};

      reset      = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      word_count = '0;
      seed       = '0;
      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst pass", pass, 0);
      chk("rst err_count", err_count, 0);
      chk("rst err_addr", err_addr, 0);
      chk("rst cs_we", {m_chipselect, m_write}, 0);
      chk("rst address", m_address, 0);
      chk("rst writedata", m_writedata, 0);
      chk("rst byteenable", m_byteenable, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 7; t++) begin
         run_one(vt[t].base, vt[t].cnt, vt[t].seed, vt[t].cor,
                 vt[t].caddr, -1, cyc, pok);
         nm = $sformatf("vec%0d", t);
         chk({nm, " cycles"}, cyc, vt[t].e_cyc);
         chk({nm, " busy"}, r_busy1, 1);
         chk({nm, " pass"}, r_pass, vt[t].e_pass);
         chk({nm, " err_count"}, r_err, vt[t].e_err);
         chk({nm, " err_addr"}, r_eaddr, vt[t].e_eaddr);
         chk({nm, " done_pulse"}, pok, 1);
         check_trace(nm, vt[t].base, int'(vt[t].cnt), vt[t].seed);
      end

      // reset during CHECK at index 3, then a clean rerun
      corrupt_en   = 1'b1;
      corrupt_addr = 13'h1;
      @(negedge clk);
      base_addr  = 13'h0;
      word_count = 14'd16;
      seed       = 32'h11110000;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!(m_chipselect && !m_write && m_address == 13'd3) &&
             cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("rstmid reached_read3",
          m_chipselect && !m_write && m_address == 13'd3, 1);
      chk("rstmid err_before", err_count, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid busy", busy, 0);
      chk("rstmid cs_we", {m_chipselect, m_write}, 0);
      chk("rstmid err_count", err_count, 0);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstmid no_late_err", err_count, 0);
      run_one(13'h0, 14'd16, 32'h11110000, 1'b0, 13'h0, -1, cyc, pok);
      chk("rerun cycles", cyc, 34);
      chk("rerun pass", r_pass, 1);
      chk("rerun err_count", r_err, 0);
      check_trace("rerun", 13'h0, 16, 32'h11110000);

      // start pulsed while busy must be ignored
      run_one(13'h40, 14'd8, 32'hCAFE0000, 1'b0, 13'h0, 3, cyc, pok);
      chk("busystart cycles", cyc, 18);
      chk("busystart pass", r_pass, 1);
      chk("busystart done_pulse", pok, 1);
      repeat (4) @(negedge clk);
      chk("busystart idle_after", busy, 0);
      check_trace("busystart", 13'h40, 8, 32'hCAFE0000);

      // random runs against the reference model
      for (int r = 0; r < 20; r++) begin
         rb = 13'($urandom);
         nn = $urandom_range(0, 40);
         rs = $urandom;
         rc = $urandom_range(0, 1);
         rca = rb + 13'($urandom_range(0, 40));
         if ($urandom_range(0, 3) == 0) rs = 32'h0 - 32'(rca - rb);
         ref_model(rb, nn, rs, rc, rca, ep, ee, ea, ec);
         run_one(rb, 14'(nn), rs, rc, rca, -1, cyc, pok);
         nm = $sformatf("rnd%0d", r);
         chk({nm, " cycles"}, cyc, ec);
         chk({nm, " pass"}, r_pass, ep);
         chk({nm, " err_count"}, r_err, ee);
         chk({nm, " err_addr"}, r_eaddr, ea);
         chk({nm, " done_pulse"}, pok, 1);
         check_trace(nm, rb, nn, rs);
      end

      // oversized word_count is clamped to the full address space
      run_one(13'h0100, 14'h3FFF, 32'h00C0FFEE, 1'b0, 13'h0, -1,
              cyc, pok);
      chk("clamp cycles", cyc, 2 * 8192 + RL + 1);
      check_trace("clamp", 13'h0100, 8192, 32'h00C0FFEE);

      chk("clken always_high", clken_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
